dmem_arbiter: RTL and testbench

- Shares the single-port 256x8 data memory between two requesters:
  - Port A: the core's load/store unit (priority requester).
  - Port B: a DMA/block-copy engine (background requester).
- Sits between the requesters and the data memory, and drives its address, write data and write enable.
- Memory reads are combinational, so a granted read returns data in the same cycle.
- Provides fixed A priority, a starvation guard for B, and B burst locking.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between a priority port A and a burst-capable port B.
// Optional build macro DMEM_ARB_STATS_EN adds a saturating 16-bit contention counter (Conflicts).
`default_nettype none

module dmem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          A_Req,
   input  logic          A_We,
   input  logic [AW-1:0] A_Addr,
   input  logic [DW-1:0] A_Wdata,
   output logic          A_Gnt,
   output logic [DW-1:0] A_Rdata,
   input  logic          B_Req,
   input  logic          B_We,
   input  logic [AW-1:0] B_Addr,
   input  logic [DW-1:0] B_Wdata,
   input  logic          B_Lock,
   output logic          B_Gnt,
   output logic [DW-1:0] B_Rdata,
   output logic [AW-1:0] Mem_Addr,
   output logic [DW-1:0] Mem_Wdata,
   output logic          Mem_WriteEn,
   input  logic [DW-1:0] Mem_Rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   Conflicts
`endif
);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      BLOCK = 1'b1
   } state_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   state_t     st, st_next;
   logic [3:0] wcnt, wcnt_next;
   logic       a_gnt, b_gnt;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         st   <= ARB;
         wcnt <= '0;
      end else begin
         st   <= st_next;
         wcnt <= wcnt_next;
      end
   end

   // Grant and state decode; B keeps the grant on the cycle it drops B_Lock.
   always_comb begin
      st_next = st;
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      case (st)
         ARB: begin
            b_gnt = B_Req & (!A_Req | (wcnt == WAIT_LIMIT));
            a_gnt = A_Req & !b_gnt;
            if (b_gnt & B_Lock) st_next = BLOCK;
         end
         BLOCK: begin
            b_gnt = B_Req;
            if (!(B_Req & B_Lock)) st_next = ARB;
         end
         default: st_next = ARB;
      endcase
   end

   always_comb begin
      wcnt_next = wcnt;
      if (b_gnt | !B_Req)
         wcnt_next = '0;
      else if (wcnt >= WAIT_LIMIT)
         wcnt_next = WAIT_LIMIT;
      else
         wcnt_next = wcnt + 4'd1;
   end

   always_comb begin
      Mem_Addr    = '0;
      Mem_Wdata   = '0;
      Mem_WriteEn = 1'b0;
      if (b_gnt) begin
         Mem_Addr    = B_Addr;
         Mem_Wdata   = B_Wdata;
         Mem_WriteEn = B_We;
      end else if (a_gnt) begin
         Mem_Addr    = A_Addr;
         Mem_Wdata   = A_Wdata;
         Mem_WriteEn = A_We;
      end
   end

   assign A_Gnt   = a_gnt;
   assign B_Gnt   = b_gnt;
   assign A_Rdata = Mem_Rdata;
   assign B_Rdata = Mem_Rdata;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflicts;

   always_ff @(posedge Clk) begin
      if (!Reset)
         conflicts <= '0;
      else if (A_Req & B_Req & (conflicts != 16'hFFFF))
         conflicts <= conflicts + 16'd1;
   end

   assign Conflicts = conflicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a
//               behavioural 256x8 combinational-read memory.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        r_clk = 1'b0;
    logic        r_reset;
    logic        r_a_req, r_a_we, r_b_req, r_b_we, r_b_lock;
    logic [7:0]  r_a_addr, r_a_wdata, r_b_addr, r_b_wdata;
    logic        w_a_gnt, w_b_gnt, w_mem_we;
    logic [7:0]  w_a_rdata, w_b_rdata, w_mem_addr, w_mem_wdata, w_mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] w_conflicts;
`endif

    logic [7:0] r_mem [256];
    int r_vectors     = 0;
    int r_miscompares = 0;

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk)
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    assign w_mem_rdata = r_mem[w_mem_addr];

    dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
        .Clk(r_clk), .Reset(r_reset),
        .A_Req(r_a_req), .A_We(r_a_we), .A_Addr(r_a_addr), .A_Wdata(r_a_wdata),
        .A_Gnt(w_a_gnt), .A_Rdata(w_a_rdata),
        .B_Req(r_b_req), .B_We(r_b_we), .B_Addr(r_b_addr), .B_Wdata(r_b_wdata),
        .B_Lock(r_b_lock), .B_Gnt(w_b_gnt), .B_Rdata(w_b_rdata),
        .Mem_Addr(w_mem_addr), .Mem_Wdata(w_mem_wdata), .Mem_WriteEn(w_mem_we),
        .Mem_Rdata(w_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .Conflicts(w_conflicts)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        r_vectors++;
        if (obs !== exp) begin
            r_miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                         input logic bl);
        r_a_req = ar; r_a_we = aw; r_a_addr = aa; r_a_wdata = ad;
        r_b_req = br; r_b_we = bw; r_b_addr = ba; r_b_wdata = bd; r_b_lock = bl;
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) r_mem[i] = 8'h00;
        r_mem[8'h30] = 8'h5C;
        r_reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 2; i++) begin
            @(negedge r_clk);
            check("rst_a_gnt", w_a_gnt, 1'b0);
            check("rst_b_gnt", w_b_gnt, 1'b0);
            check("rst_we", w_mem_we, 1'b0);
            check("rst_addr", w_mem_addr, 8'h00);
            check("rst_wdata", w_mem_wdata, 8'h00);
            tick();
        end
        r_reset = 1'b1;

        drive(1, 1, 8'h10, 8'hAB, 0, 0, 8'h00, 8'h00, 0);
        @(negedge r_clk);
        check("awr_gnt", w_a_gnt, 1'b1);
        check("awr_b_gnt", w_b_gnt, 1'b0);
        check("awr_addr", w_mem_addr, 8'h10);
        check("awr_we", w_mem_we, 1'b1);
        check("awr_wdata", w_mem_wdata, 8'hAB);
        tick();
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge r_clk);
        check("ard_gnt", w_a_gnt, 1'b1);
        check("ard_we", w_mem_we, 1'b0);
        check("ard_rdata", w_a_rdata, 8'hAB);
        tick();

        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            logic w_exp_b;
            w_exp_b = (i == 4) || (i == 9);
            @(negedge r_clk);
            check("cont_b_gnt", w_b_gnt, w_exp_b);
            check("cont_a_gnt", w_a_gnt, !w_exp_b);
            check("cont_addr", w_mem_addr, w_exp_b ? 8'h30 : 8'h10);
            if (w_exp_b) begin
                check("cont_b_rdata", w_b_rdata, 8'h5C);
            end
            tick();
        end
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge r_clk);
        check("idle_a_gnt", w_a_gnt, 1'b0);
        check("idle_b_gnt", w_b_gnt, 1'b0);
        tick();

        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge r_clk);
            check("lock_b_gnt", w_b_gnt, (i >= 4));
            check("lock_a_gnt", w_a_gnt, (i < 4));
            tick();
        end
        r_b_lock = 1'b0;
        @(negedge r_clk);
        check("unlock_b_gnt", w_b_gnt, 1'b1);
        check("unlock_a_gnt", w_a_gnt, 1'b0);
        tick();
        r_b_req = 1'b0;
        @(negedge r_clk);
        check("post_lock_a_gnt", w_a_gnt, 1'b1);
        check("post_lock_b_gnt", w_b_gnt, 1'b0);
        tick();

        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h01, 1);
        @(negedge r_clk);
        check("burst0_b_gnt", w_b_gnt, 1'b1);
        check("burst0_we", w_mem_we, 1'b1);
        check("burst0_addr", w_mem_addr, 8'h20);
        tick();
        r_b_addr = 8'h21; r_b_wdata = 8'h02; r_reset = 1'b0;
        @(negedge r_clk);
        check("burst1_b_gnt", w_b_gnt, 1'b1);
        check("burst1_we", w_mem_we, 1'b1);
        tick();
        r_reset = 1'b1;
        drive(1, 0, 8'h20, 8'h00, 1, 1, 8'h22, 8'h03, 1);
        @(negedge r_clk);
        check("after_rst_a_gnt", w_a_gnt, 1'b1);
        check("after_rst_b_gnt", w_b_gnt, 1'b0);
        check("after_rst_mem20", w_a_rdata, 8'h01);
        tick();

        @(negedge r_clk);
        check("wpre_a_gnt", w_a_gnt, 1'b1);
        tick();
        r_reset = 1'b0;
        @(negedge r_clk);
        check("wrst_a_gnt", w_a_gnt, 1'b1);
        tick();
        r_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge r_clk);
            check("wclr_b_gnt", w_b_gnt, (i == 4));
            check("wclr_a_gnt", w_a_gnt, (i != 4));
            tick();
        end
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        tick();

        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h44, 8'h00, 0);
        @(negedge r_clk);
        check("bonly_gnt0", w_b_gnt, 1'b1);
        check("bonly_addr0", w_mem_addr, 8'h44);
        tick();
        r_b_addr = 8'h45;
        @(negedge r_clk);
        check("bonly_gnt1", w_b_gnt, 1'b1);
        check("bonly_addr1", w_mem_addr, 8'h45);
        tick();
        r_a_req = 1'b1; r_a_addr = 8'h21;
        for (int i = 0; i < 5; i++) begin
            @(negedge r_clk);
            check("bonly_wait_b_gnt", w_b_gnt, (i == 4));
            if (i == 0) begin
                check("mem21_rdata", w_a_rdata, 8'h02);
            end
            tick();
        end
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        tick();

`ifdef DMEM_ARB_STATS_EN
        r_reset = 1'b0;
        tick();
        r_reset = 1'b1;
        @(negedge r_clk);
        check("stats_rst", w_conflicts, 16'd0);
        tick();
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00, 0);
        for (int i = 0; i < 10; i++) tick();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        @(negedge r_clk);
        check("stats_10", w_conflicts, 16'd10);
        tick();
        r_reset = 1'b0;
        tick();
        r_reset = 1'b1;
        @(negedge r_clk);
        check("stats_clr", w_conflicts, 16'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
